// File: rtl/rot_pkg.sv
// ---------------------------------------------------------------------------
// rot_pkg
//   Shared definitions for the rotate_sched scheduler and its rotator datapath.
//   Contents:
//     ROT_DW            operand width handled by the rotator
//     ST_IDLE/RUN/DONE  scheduler state encoding
//     WW_*              rotator pass selectors (element width being swapped)
//     lowest_set()      picks the next pass from a remaining-step mask
// ---------------------------------------------------------------------------
package rot_pkg;

  localparam int ROT_DW = 64;

  // Scheduler states, kept as plain constants so older tools and
  // waveform viewers see a simple 2-bit register.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Pass selectors: each swaps the two halves of every element of the
  // next larger size (nibbles in a byte, bytes in a halfword, ...).
  localparam logic [1:0] WW_NIB  = 2'b00;
  localparam logic [1:0] WW_BYTE = 2'b01;
  localparam logic [1:0] WW_HALF = 2'b10;
  localparam logic [1:0] WW_WORD = 2'b11;

  // Passes run in ascending order, so the next one is the lowest set bit.
  // An all-zero mask never reaches this in RUN; it falls through to WW_WORD.
  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    if (m[0]) return WW_NIB;
    if (m[1]) return WW_BYTE;
    if (m[2]) return WW_HALF;
    return WW_WORD;
  endfunction

endpackage

// File: rtl/rotate_sched_rotator.sv
// ---------------------------------------------------------------------------
// rotator
//   One combinational permutation pass over a 64-bit operand. Each pass
//   swaps the two halves of every element of a given size.
//   Ports:
//     din   in   ROT_DW  operand
//     ww    in   2       pass select (WW_NIB / WW_BYTE / WW_HALF / WW_WORD)
//     dout  out  ROT_DW  permuted operand
// ---------------------------------------------------------------------------
module rotator
  import rot_pkg::*;
(
  input  logic [ROT_DW-1:0] din,
  input  logic [1:0]        ww,
  output logic [ROT_DW-1:0] dout
);

  // NOTE: every branch of a combinational block must assign all outputs;
  // the default at the top keeps this block from inferring a latch.
  always_comb begin
    dout = din;
    unique case (ww)
      WW_NIB: begin
        for (int b = 0; b < ROT_DW / 8; b++) begin
          dout[8*b +: 8] = {din[8*b +: 4], din[8*b+4 +: 4]};
        end
      end
      WW_BYTE: begin
        for (int h = 0; h < ROT_DW / 16; h++) begin
          dout[16*h +: 16] = {din[16*h +: 8], din[16*h+8 +: 8]};
        end
      end
      WW_HALF: begin
        for (int w = 0; w < ROT_DW / 32; w++) begin
          dout[32*w +: 32] = {din[32*w +: 16], din[32*w+16 +: 16]};
        end
      end
      WW_WORD: begin
        dout = {din[31:0], din[63:32]};
      end
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/rotate_sched.sv
// ---------------------------------------------------------------------------
// rotate_sched
//   Round-robin scheduler sharing one rotator among NREQ (1..4) requesters.
//   An accepted request is permuted by one rotator pass per set mask bit,
//   lowest bit first, then held until the consumer takes it.
//   Optional build macro ROTATE_SCHED_PERF_EN adds per-requester saturating
//   acceptance counters on port perf_grants.
//   Ports:
//     clk          in   1            system clock
//     reset        in   1            synchronous active-high reset
//     req_valid    in   NREQ         request i pending
//     req_ready    out  NREQ         request i accepted this cycle (one-hot or 0)
//     req_data     in   [0:64N-1]    operand i in bits [64i:64i+63], 64i = MSB
//     req_mask     in   4N           step mask i in bits [4i+3:4i]
//     rsp_valid    out  1            result available
//     rsp_ready    in   1            consumer takes the result
//     rsp_data     out  [0:63]       permuted operand
//     rsp_id       out  2            originating requester
//     busy         out  1            not idle
//     perf_grants  out  16N          (ROTATE_SCHED_PERF_EN only) counters
// ---------------------------------------------------------------------------
module rotate_sched
  import rot_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [0:64*NREQ-1]   req_data,
  input  logic [4*NREQ-1:0]    req_mask,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [0:63]          rsp_data,
  output logic [1:0]           rsp_id,
  output logic                 busy
`ifdef ROTATE_SCHED_PERF_EN
  ,
  output logic [16*NREQ-1:0]   perf_grants
`endif
);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [1:0]        state;
  logic [ROT_DW-1:0] acc;
  logic [3:0]        rem;
  logic [1:0]        id;
  logic [1:0]        last_grant;

  // -------------------------------------------------------------------------
  // Arbiter: first valid requester after last_grant, wrapping at NREQ.
  // Two ascending sweeps avoid a modulo: the first covers indices above
  // last_grant, the second picks up the wrapped ones.
  // -------------------------------------------------------------------------
  logic       grant_found;
  logic [1:0] grant_idx;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found && req_valid[i] && (i > int'(last_grant))) begin
        grant_found = 1'b1;
        grant_idx   = 2'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found && req_valid[i]) begin
        grant_found = 1'b1;
        grant_idx   = 2'(i);
      end
    end
  end

  // Acceptance only in IDLE and never while reset is asserted, so an
  // upstream stage cannot lose a request into a block that is clearing.
  logic accept;
  assign accept = (state == ST_IDLE) && grant_found && !reset;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = accept && (grant_idx == 2'(i));
    end
  end

  // Operand and mask of the winning lane.
  logic [ROT_DW-1:0] sel_data;
  logic [3:0]        sel_mask;

  always_comb begin
    sel_data = '0;
    sel_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == 2'(i)) begin
        sel_data = req_data[64*i +: 64];
        sel_mask = req_mask[4*i +: 4];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Shared rotator: one pass per RUN cycle, lowest remaining step first.
  // -------------------------------------------------------------------------
  logic [1:0]        run_ww;
  logic [3:0]        rem_next;
  logic [ROT_DW-1:0] rot_out;

  assign run_ww   = lowest_set(rem);
  assign rem_next = rem & ~(4'b0001 << run_ww);

  rotator u_rotator (
    .din  (acc),
    .ww   (run_ww),
    .dout (rot_out)
  );

  // -------------------------------------------------------------------------
  // Control and datapath registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      acc        <= '0;
      rem        <= '0;
      id         <= '0;
      last_grant <= 2'(NREQ - 1);
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            acc        <= sel_data;
            rem        <= sel_mask;
            id         <= grant_idx;
            last_grant <= grant_idx;
            // A zero mask is a pass-through and skips RUN entirely.
            state      <= (sel_mask != 4'b0000) ? ST_RUN : ST_DONE;
          end
        end
        ST_RUN: begin
          acc <= rot_out;
          rem <= rem_next;
          if (rem_next == 4'b0000) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Response: exposed only in DONE, so the data bus is quiet while the
  // accumulator is being rotated.
  // -------------------------------------------------------------------------
  assign rsp_valid = (state == ST_DONE);
  assign rsp_data  = rsp_valid ? acc : '0;
  assign rsp_id    = rsp_valid ? id : 2'b00;
  assign busy      = (state != ST_IDLE);

`ifdef ROTATE_SCHED_PERF_EN
  // Per-requester acceptance counters; they saturate rather than wrap so a
  // long run never reports a misleadingly small count.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_grants <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (accept && (grant_idx == 2'(i)) && (perf_grants[16*i +: 16] != 16'hFFFF)) begin
          perf_grants[16*i +: 16] <= perf_grants[16*i +: 16] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_rotate_sched.sv
// ---------------------------------------------------------------------------
// tb_rotate_sched
//   Self-checking bench for rotate_sched with NREQ=2. Expected results come
//   from a nibble-index model: a mask m moves nibble p to position p^m,
//   because each pass ww=j exchanges nibble indices that differ in bit j.
//   Grants come from a round-robin model that tracks the last winner.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rotate_sched;

  localparam int NREQ = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [0:64*NREQ-1] req_data;
  logic [4*NREQ-1:0] req_mask;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [0:63]       rsp_data;
  logic [1:0]        rsp_id;
  logic              busy;
`ifdef ROTATE_SCHED_PERF_EN
  logic [16*NREQ-1:0] perf_grants;
`endif

  int checks = 0;
  int errors = 0;
  int last_grant_m;

  rotate_sched #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_mask  (req_mask),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
`ifdef ROTATE_SCHED_PERF_EN
    ,
    .perf_grants (perf_grants)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference permutation: output nibble p takes input nibble p^mask.
  function automatic logic [63:0] perm(input logic [63:0] d, input logic [3:0] m);
    logic [63:0] r;
    r = '0;
    for (int p = 0; p < 16; p++) r[4*p +: 4] = d[4*(p ^ int'(m)) +: 4];
    return r;
  endfunction

  // Reference arbiter: scan forward from the last winner.
  function automatic int pick(input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (last_grant_m + k) % NREQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // One full transaction, entered and left at a negedge in IDLE with
  // rsp_ready low. Checks grant, latency, result, id and DONE stability.
  task automatic txn(input logic [1:0] v, input logic [63:0] d0, input logic [63:0] d1,
                     input logic [3:0] m0, input logic [3:0] m1, input int stall,
                     input bit use_lit, input logic [63:0] lit);
    int          w, n;
    logic [3:0]  m;
    logic [63:0] exp_d;
    req_valid = v;
    req_data  = {d0, d1};
    req_mask  = {m1, m0};
    w         = pick(v);
    m         = (w == 1) ? m1 : m0;
    exp_d     = use_lit ? lit : perm((w == 1) ? d1 : d0, m);
    #1;
    check("grant", 64'(req_ready), 64'(2'b01 << w));
    @(posedge clk);
    last_grant_m = w;
    @(negedge clk);
    // Later input changes must not disturb the request in flight.
    req_valid = '0;
    req_data  = {$urandom, $urandom, $urandom, $urandom};
    req_mask  = 8'($urandom);
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency", 64'(n), 64'(1 + $countones(m)));
    check("rsp_data", rsp_data, exp_d);
    check("rsp_id", 64'(rsp_id), 64'(w));
    check("busy_done", 64'(busy), 64'd1);
    for (int s = 0; s < stall; s++) begin
      req_valid = 2'b11;
      @(negedge clk);
      check("stall_valid", 64'(rsp_valid), 64'd1);
      check("stall_data", rsp_data, exp_d);
      check("stall_id", 64'(rsp_id), 64'(w));
      check("stall_ready", 64'(req_ready), 64'd0);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_valid", 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    int seen, grants, exp_g;
    localparam logic [63:0] OPA = 64'h0123456789ABCDEF;

    // ---- reset state; valids high to show req_ready is gated by reset ----
    reset     = 1'b1;
    req_valid = 2'b11;
    req_data  = {OPA, OPA};
    req_mask  = 8'hFF;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_valid", 64'(rsp_valid), 64'd0);
    check("rst_data", rsp_data, 64'd0);
    check("rst_id", 64'(rsp_id), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset        = 1'b0;
    req_valid    = '0;
    last_grant_m = NREQ - 1;
    @(negedge clk);

    // ---- directed passes from known operands ----
    txn(2'b01, OPA, 64'd0, 4'b1111, 4'b0000, 0, 1'b1, 64'hFEDCBA9876543210);
    txn(2'b10, 64'd0, OPA, 4'b0000, 4'b0001, 0, 1'b1, 64'h1032547698BADCFE);
    txn(2'b01, OPA, 64'd0, 4'b1000, 4'b0000, 0, 1'b1, 64'h89ABCDEF01234567);
    txn(2'b10, 64'd0, OPA, 4'b0000, 4'b0110, 0, 1'b1, 64'h67452301EFCDAB89);
    txn(2'b01, OPA, 64'd0, 4'b0000, 4'b0000, 0, 1'b1, OPA);

    // ---- DONE held for 10 cycles with both requesters pending ----
    txn(2'b11, {$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom), 4'($urandom),
        10, 1'b0, 64'd0);

    // ---- reset during RUN of a 4-step request ----
    req_valid = 2'b01;
    req_data  = {OPA, OPA};
    req_mask  = 8'hFF;
    #1;
    check("rr_grant", 64'(req_ready), 64'b01);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    check("rr_busy_run", 64'(busy), 64'd1);
    reset     = 1'b1;
    req_valid = 2'b11;
    #1;
    check("rr_ready_in_reset", 64'(req_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("rr_ready", 64'(req_ready), 64'd0);
    check("rr_valid", 64'(rsp_valid), 64'd0);
    check("rr_data", rsp_data, 64'd0);
    check("rr_id", 64'(rsp_id), 64'd0);
    check("rr_busy", 64'(busy), 64'd0);
    reset     = 1'b0;
    req_valid = '0;
    seen      = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("rr_no_rsp", 64'(seen), 64'd0);
    last_grant_m = NREQ - 1;

    // ---- both requesters held valid: grants alternate 0,1,0,1,... ----
    req_valid = 2'b11;
    req_data  = {OPA, ~OPA};
    req_mask  = 8'h00;
    rsp_ready = 1'b1;
    grants    = 0;
    exp_g     = 0;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (req_ready != '0) begin
        check("cont_onehot", 64'($countones(req_ready)), 64'd1);
        check("cont_order", 64'(req_ready), 64'(2'b01 << exp_g));
        last_grant_m = exp_g;
        exp_g = (exp_g + 1) % NREQ;
        grants++;
      end else if (rsp_valid) begin
        check("cont_id", 64'(rsp_id), 64'(last_grant_m));
      end
      @(negedge clk);
    end
    check("cont_grants", 64'(grants), 64'd8);
    req_valid = '0;
    @(negedge clk);
    rsp_ready = 1'b0;

    // ---- randomized transactions against the model ----
    for (int t = 0; t < 40; t++) begin
      txn(2'($urandom_range(1, 3)), {$urandom, $urandom}, {$urandom, $urandom},
          4'($urandom), 4'($urandom), $urandom_range(0, 3), 1'b0, 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rotate_sched.md
# rotate_sched

Round-robin scheduler that shares one `rotator` datapath among up to four requesters and sequences multi-step permutations through it. Each request carries a 64-bit operand and a 4-bit step mask. The block applies one rotator pass per cycle for each selected element width, then returns the result with the requester's ID. It sits between the issue stage and the permute unit, so several clients can reuse one rotator instead of each holding a copy.

## Interface
- `NREQ`, default 2: number of requesters; legal range 1..4.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  request i is pending.
- `req_ready`  out  NREQ  request i is accepted this cycle; at most one bit is high.
- `req_data`  in  [0:64*NREQ-1]  operand of requester i in bits [64i:64i+63]; bit 64i is the MSB.
- `req_mask`  in  4*NREQ  step mask of requester i in bits [4i+3:4i]; bit j selects pass ww=j.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes the result.
- `rsp_data`  out  [0:63]  permuted operand.
- `rsp_id`  out  2  index of the originating requester.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Three states:
  - IDLE: no request held.
  - RUN: applying rotator passes.
  - DONE: result waiting for the consumer.
- IDLE:
  - Winner = first i with `req_valid[i]`, searching from `last_grant+1` mod NREQ.
  - `req_ready[winner]` = 1 combinationally; a request is accepted when `req_valid` & `req_ready` are both high.
  - On acceptance: `acc` ← operand, `rem` ← mask, `id` ← winner, `last_grant` ← winner.
  - Next state is RUN if the mask is non-zero, otherwise DONE (pass-through).
- RUN:
  - j = lowest set bit of `rem`.
  - `acc` ← rotator(`acc`, ww=j); clear `rem[j]`.
  - Go to DONE on the cycle the last bit clears.
- Pass semantics by ww value:
  - 00: swap the two nibbles of each byte.
  - 01: swap the two bytes of each halfword.
  - 10: swap the two halfwords of each word.
  - 11: swap the two words.
- Passes are applied in ascending ww order. Mask 4'b1111 reverses the 16 nibbles of the operand.
- DONE:
  - `rsp_valid` = 1; `rsp_data` = `acc` and `rsp_id` = `id`, both stable.
  - On `rsp_ready`, return to IDLE. No request is accepted in DONE; the next acceptance happens in IDLE, one cycle after the response handshake at the earliest.
- `req_ready` is all-zero outside IDLE. Requester inputs are sampled only at acceptance; later changes have no effect on the request in flight.
- Unused upper `req_*` lanes (i ≥ NREQ) do not exist. `rsp_id` upper bits are 0 when NREQ ≤ 2.

## Timing
- Reset values:
  - state = IDLE, `last_grant` = NREQ-1, so requester 0 wins first.
  - `acc` = 0, `rem` = 0, `id` = 0.
  - `req_ready` = 0 while `reset` is high.
  - `rsp_valid` = 0, `rsp_data` = 0, `rsp_id` = 0, `busy` = 0.
- Latency: acceptance in cycle T, then `rsp_valid` first high in cycle T+1+popcount(mask). Minimum 1, maximum 5.
- Throughput: one request per 2+popcount cycles when `rsp_ready` is held high.
- `rsp_valid` stays high until `rsp_ready`; `rsp_data` and `rsp_id` must not change while it is high.
- Reset asserted mid-RUN or mid-DONE: the in-flight request is dropped, no response is issued, and all registers take their reset values on the next edge.
- Simultaneous valid requests: exactly one is granted per IDLE cycle. Starvation-free: with all requesters valid, grants cycle 0,1,…,NREQ-1.

## Configuration
- `ROTATE_SCHED_PERF_EN` defined:
  - Adds output `perf_grants` [16*NREQ-1:0]: per-requester saturating 16-bit acceptance counters, lane i in bits [16i+15:16i].
  - Counters clear on reset and stick at 16'hFFFF.
- Macro undefined: the port and counters are absent, and all other behaviour is identical.

## Structure
- Shared package `rot_pkg`:
  - state encoding (`ST_IDLE`, `ST_RUN`, `ST_DONE`)
  - `WW_NIB`=2'b00, `WW_BYTE`=2'b01, `WW_HALF`=2'b10, `WW_WORD`=2'b11
  - `ROT_DW`=64
- One sub-module, `rotator`, fed by `acc` and the ww selected from `rem`. Its output drives `acc` through a register. The arbiter and priority encoder stay inline.

## Test plan
- NREQ=2; req0 data 64'h0123456789ABCDEF, mask 4'b1111, `rsp_ready`=1 → accepted at T, `rsp_valid` at T+5, `rsp_data`=64'hFEDCBA9876543210, `rsp_id`=0.
- Mask 4'b0001 on 64'h0123456789ABCDEF → 64'h1032547698BADCFE at T+2. Mask 4'b1000 → 64'h89ABCDEF01234567 at T+2.
- Mask 4'b0110 → 64'h67452301EFCDAB89 at T+3. Mask 4'b0000 → operand unchanged at T+1.
- Both requesters held valid continuously after reset → grant order 0,1,0,1; `req_ready` never has two bits high at once.
- `rsp_ready` held low for 10 cycles in DONE → `rsp_valid`, `rsp_data` and `rsp_id` stable, `req_ready`=0 throughout; release → IDLE next cycle.
- `reset` pulsed during RUN of a 4-step request → no `rsp_valid`; all outputs at reset values; next grant goes to requester 0.
